// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtraction controller.
// Streams a WIDTH-bit operand pair LSB first through a one-bit subtractor cell
// (two half-subtractor stages plus a borrow flip-flop) and returns the
// difference and final borrow under a start/busy/done handshake.
// Optional feature macro: SERSUB_ZERO_EN adds the registered `zero` result flag.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
`ifdef SERSUB_ZERO_EN
  output logic             zero,
`endif
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
`ifdef SERSUB_ZERO_EN
  logic             acc_q, acc_d;
  logic             zero_q, zero_d;
`endif

  logic t, p, q, dbit, br_next, last;

  // Subtractor cell and next-state sequencing.
  always_comb begin
    // Stage 1 on the operand LSBs, stage 2 folds in the stored borrow.
    t       = a_q[0] ^ b_q[0];
    p       = ~a_q[0] & b_q[0];
    dbit    = t ^ br_q;
    q       = ~t & br_q;
    br_next = p | q;
    last    = (cnt_q == CW'(WIDTH - 1));

    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SERSUB_ZERO_EN
    acc_d   = acc_q;
    zero_d  = zero_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERSUB_ZERO_EN
          acc_d   = 1'b0;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        d_d   = {dbit, d_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        cnt_d = cnt_q + CW'(1);
`ifdef SERSUB_ZERO_EN
        acc_d = acc_q | dbit;
`endif
        if (last) begin
          bout_d  = br_next;
`ifdef SERSUB_ZERO_EN
          zero_d  = ~(acc_q | dbit);
`endif
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERSUB_ZERO_EN
      acc_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
`ifdef SERSUB_ZERO_EN
      acc_q   <= acc_d;
      zero_q  <= zero_d;
`endif
    end
  end

  // Handshake outputs decode the state register only, so no input reaches them.
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign d    = d_q;
  assign bout = bout_q;
`ifdef SERSUB_ZERO_EN
  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): vector table plus
// hand-written sequences for ignored start, mid-run reset and held start.
module tb_serial_sub_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, bout;
  logic [WIDTH-1:0] d;
`ifdef SERSUB_ZERO_EN
  logic             zero;
`endif

  int checks = 0;
  int failures = 0;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
`ifdef SERSUB_ZERO_EN
    .zero  (zero),
`endif
    .bout  (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] exp_d;
    logic       exp_bout;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, then count busy cycles until done.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] exp_d, input logic exp_bout,
                        input logic exp_zero, input logic chk_zero);
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = -1;
    a = va;
    b = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va;
    b = ~vb;
    for (int k = 0; k <= 20; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_at = k;
        break;
      end
      tick();
    end
    chk("done_latency", 64'(done_at), 64'(WIDTH));
    chk("busy_cycles", 64'(busy_cnt), 64'(WIDTH));
    chk("busy_with_done", {63'd0, busy}, 64'd0);
    chk("d", {56'd0, d}, {56'd0, exp_d});
    chk("bout", {63'd0, bout}, {63'd0, exp_bout});
`ifdef SERSUB_ZERO_EN
    if (chk_zero) chk("zero", {63'd0, zero}, {63'd0, exp_zero});
`else
    if (chk_zero && exp_zero) begin end
`endif
    tick();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    tick();
    chk("d_held", {56'd0, d}, {56'd0, exp_d});
  endtask

  initial begin
    int ndone;
    int last_done;
    int interval_bad;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'h81, 8'h80, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[8] = '{8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_d", {56'd0, d}, 64'd0);
    chk("rst_bout", {63'd0, bout}, 64'd0);
`ifdef SERSUB_ZERO_EN
    chk("rst_zero", {63'd0, zero}, 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].exp_d, vecs[i].exp_bout, vecs[i].exp_zero, 1'b1);
    end

    // start pulses during RUN are ignored; exactly one done with the original result.
    a = 8'h5A;
    b = 8'h3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 3 || k == 7) begin
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        ndone++;
        chk("ign_d", {56'd0, d}, 64'h1E);
        chk("ign_bout", {63'd0, bout}, 64'd0);
      end
    end
    chk("ign_done_count", 64'(ndone), 64'd1);

    // Reset for one edge at RUN cycle 4 aborts the operation.
    a = 8'h5A;
    b = 8'h3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 4; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_d", {56'd0, d}, 64'd0);
    chk("abort_bout", {63'd0, bout}, 64'd0);
`ifdef SERSUB_ZERO_EN
    chk("abort_zero", {63'd0, zero}, 64'd0);
`endif
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("abort_quiet", 64'(ndone), 64'd0);
    run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b1);

    // start held high: a new accept every WIDTH+2 clocks.
    a = 8'h03;
    b = 8'h01;
    start = 1'b1;
    ndone = 0;
    last_done = -1;
    interval_bad = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) begin
        ndone++;
        chk("held_d", {56'd0, d}, 64'h02);
        chk("held_bout", {63'd0, bout}, 64'd0);
        if (last_done >= 0 && (k - last_done) != WIDTH + 2) interval_bad++;
        last_done = k;
      end
    end
    start = 1'b0;
    chk("held_done_count", 64'(ndone), 64'd3);
    chk("held_interval", 64'(interval_bad), 64'd0);
    for (int k = 0; k < 12; k++) tick();
    chk("held_idle", {62'd0, busy, done}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
